sram_wr_arbiter: RTL and testbench

Shares the single write port of a 1R1W SRAM (SRAM_DEPTH x SRAM_WIDTH) among NUM_REQ requesters using round-robin arbitration. After reset, and on request, it sequences an initialization sweep that writes INIT_VALUE to every entry. This gives non-resettable arrays a defined state. It sits directly in front of the SRAM's addrWr_i/we_i/data_i pins; read ports bypass it.

---
 rtl/sram_wr_arbiter_if.sv | 26 ++
 rtl/sram_wr_arbiter.sv | 114 +++++++++++
 tb/tb_sram_wr_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sram_wr_arbiter_if.sv
// rtl/sram_wr_arbiter_if.sv - requester and SRAM write-port bundle for sram_wr_arbiter
interface sram_wr_arbiter_if #(
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic                          reinit_i;
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ*SRAM_INDEX-1:0] addr_i;
    logic [NUM_REQ*SRAM_WIDTH-1:0] data_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic                          init_done_o;
    logic                          we_o;
    logic [SRAM_INDEX-1:0]         addrWr_o;
    logic [SRAM_WIDTH-1:0]         data_o;

    modport slave (
        input  reinit_i, req_i, addr_i, data_i,
        output gnt_o, init_done_o, we_o, addrWr_o, data_o
    );

    modport master (
        output reinit_i, req_i, addr_i, data_i,
        input  gnt_o, init_done_o, we_o, addrWr_o, data_o
    );
endinterface

// File: rtl/sram_wr_arbiter.sv
// rtl/sram_wr_arbiter.sv - round-robin SRAM write-port arbiter with init sweep
module sram_wr_arbiter #(
    parameter int                      SRAM_DEPTH = 64,
    parameter int                      SRAM_INDEX = 6,
    parameter int                      SRAM_WIDTH = 32,
    parameter int                      NUM_REQ    = 4,
    parameter logic [SRAM_WIDTH-1:0]   INIT_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_wr_arbiter_if.slave     bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = SRAM_INDEX + 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic                   we_q;
    logic [SRAM_INDEX-1:0]  addr_q;
    logic [SRAM_WIDTH-1:0]  data_q;
    logic                   init_done_q;

    logic                   gnt_valid;
    logic [PTR_W-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]     gnt;
    logic [SRAM_INDEX-1:0]  sel_addr;
    logic [SRAM_WIDTH-1:0]  sel_data;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // Search starts at rr_ptr and wraps; reinit_i suppresses any grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt       = '0;
        sel_addr  = '0;
        sel_data  = '0;
        if (state_q == RUN && !bus.reinit_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_valid && bus.req_i[wrap_add(rr_ptr_q, i)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = wrap_add(rr_ptr_q, i);
                end
            end
        end
        if (gnt_valid) gnt[gnt_idx] = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                sel_addr = bus.addr_i[k*SRAM_INDEX +: SRAM_INDEX];
                sel_data = bus.data_i[k*SRAM_WIDTH +: SRAM_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (bus.reinit_i) begin
                        cnt_q <= '0;
                        we_q  <= 1'b0;
                    end else begin
                        we_q   <= 1'b1;
                        addr_q <= cnt_q[SRAM_INDEX-1:0];
                        data_q <= INIT_VALUE;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(SRAM_DEPTH - 1)) begin
                            state_q     <= RUN;
                            init_done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.reinit_i) begin
                        state_q     <= INIT;
                        cnt_q       <= '0;
                        init_done_q <= 1'b0;
                        we_q        <= 1'b0;
                    end else if (gnt_valid) begin
                        we_q     <= 1'b1;
                        addr_q   <= sel_addr;
                        data_q   <= sel_data;
                        rr_ptr_q <= wrap_add(gnt_idx, 1);
                    end else begin
                        we_q <= 1'b0;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.init_done_o = init_done_q;
    assign bus.we_o        = we_q;
    assign bus.addrWr_o    = addr_q;
    assign bus.data_o      = data_q;
endmodule

// File: tb/tb_sram_wr_arbiter.sv
// tb/tb_sram_wr_arbiter.sv - directed self-checking bench for sram_wr_arbiter
module tb_sram_wr_arbiter;
    localparam int          DEPTH = 16;
    localparam int          IDX   = 4;
    localparam int          W     = 32;
    localparam int          NR    = 4;
    localparam logic [31:0] IV    = 32'hA5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [W-1:0] mem [DEPTH];

    sram_wr_arbiter_if #(.SRAM_INDEX(IDX), .SRAM_WIDTH(W), .NUM_REQ(NR)) bus ();

    sram_wr_arbiter #(
        .SRAM_DEPTH(DEPTH), .SRAM_INDEX(IDX), .SRAM_WIDTH(W),
        .NUM_REQ(NR), .INIT_VALUE(IV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.we_o) mem[bus.addrWr_o] <= bus.data_o;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [IDX-1:0] a, input logic [W-1:0] d);
        bus.addr_i[k*IDX +: IDX] = a;
        bus.data_i[k*W +: W]     = d;
    endtask

    task automatic check_write(input string tag, input logic [IDX-1:0] a, input logic [W-1:0] d);
        check({tag, "_we"}, 64'(bus.we_o), 64'd1);
        check({tag, "_addr"}, 64'(bus.addrWr_o), 64'(a));
        check({tag, "_data"}, 64'(bus.data_o), 64'(d));
    endtask

    task automatic check_sweep(input string tag);
        for (int e = 0; e < DEPTH; e++) begin
            tick();
            check_write(tag, IDX'(e), IV);
            check({tag, "_done"}, 64'(bus.init_done_o), 64'(e == DEPTH - 1));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, 64'(bus.we_o), 64'd0);
        check({tag, "_addr"}, 64'(bus.addrWr_o), 64'd0);
        check({tag, "_data"}, 64'(bus.data_o), 64'd0);
        check({tag, "_done"}, 64'(bus.init_done_o), 64'd0);
        check({tag, "_gnt"}, 64'(bus.gnt_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.reinit_i = 1'b0;
        bus.req_i    = '0;
        bus.addr_i   = '0;
        bus.data_i   = '0;
        for (int k = 0; k < NR; k++) set_src(k, IDX'(k + 1), 32'h1000 + W'(k));

        // 1: reset values, init sweep, idle edge
        tick();
        tick();
        check_zero("rst");
        reset = 1'b1;
        check_sweep("sweep1");
        tick();
        check("idle_we", 64'(bus.we_o), 64'd0);
        check("idle_done", 64'(bus.init_done_o), 64'd1);
        check("idle_addr_hold", 64'(bus.addrWr_o), 64'd15);
        check("mem3_init", 64'(mem[3]), 64'hA5);

        // 2: all requesting, pointer at 0
        bus.req_i = 4'b1111;
        #1;
        for (int j = 0; j < 5; j++) begin
            check("rr_gnt", 64'(bus.gnt_o), 64'(4'b0001 << (j % 4)));
            tick();
            check_write("rr_wr", IDX'((j % 4) + 1), 32'h1000 + W'(j % 4));
        end
        bus.req_i = 4'b0000;
        tick();
        check("rr_idle_we", 64'(bus.we_o), 64'd0);
        check("rr_idle_addr", 64'(bus.addrWr_o), 64'd1);

        // 3: pointer now 1
        bus.req_i = 4'b0100;
        #1;
        check("p3_gnt2", 64'(bus.gnt_o), 64'b0100);
        tick();
        check_write("p3_wr2", 4'd3, 32'h1002);
        bus.req_i = 4'b1001;
        #1;
        check("p3_gnt3", 64'(bus.gnt_o), 64'b1000);
        tick();
        check_write("p3_wr3", 4'd4, 32'h1003);
        bus.req_i = 4'b0001;
        #1;
        check("p3_gnt0", 64'(bus.gnt_o), 64'b0001);
        tick();
        check_write("p3_wr0", 4'd1, 32'h1000);
        bus.req_i = 4'b0000;
        tick();
        check("p3_idle_we", 64'(bus.we_o), 64'd0);

        // 4: reinit in RUN with requester 1 pending, then reinit mid-sweep
        bus.req_i    = 4'b0010;
        bus.reinit_i = 1'b1;
        #1;
        check("ri_gnt", 64'(bus.gnt_o), 64'd0);
        tick();
        bus.reinit_i = 1'b0;
        check("ri_we", 64'(bus.we_o), 64'd0);
        check("ri_done", 64'(bus.init_done_o), 64'd0);
        #1;
        check("ri_init_gnt", 64'(bus.gnt_o), 64'd0);
        for (int e = 0; e < 7; e++) begin
            tick();
            check_write("ri_part", IDX'(e), IV);
        end
        bus.reinit_i = 1'b1;
        tick();
        bus.reinit_i = 1'b0;
        check("ri2_we", 64'(bus.we_o), 64'd0);
        check("ri2_done", 64'(bus.init_done_o), 64'd0);
        check_sweep("sweep2");
        #1;
        check("ri_gnt1", 64'(bus.gnt_o), 64'b0010);
        tick();
        check_write("ri_wr1", 4'd2, 32'h1001);
        bus.req_i = 4'b0000;
        tick();
        check("ri_idle_we", 64'(bus.we_o), 64'd0);

        // 5: reset at sweep cnt=9
        bus.reinit_i = 1'b1;
        tick();
        bus.reinit_i = 1'b0;
        for (int e = 0; e < 9; e++) begin
            tick();
            check_write("r5_part", IDX'(e), IV);
        end
        reset = 1'b0;
        #1;
        check_zero("r5_async");
        for (int c = 0; c < 3; c++) begin
            tick();
            check_zero("r5_hold");
        end
        reset = 1'b1;
        check_sweep("sweep3");

        // 6: same address from two requesters, later grant wins
        set_src(0, 4'd5, 32'h11);
        set_src(2, 4'd5, 32'h22);
        bus.req_i = 4'b0101;
        #1;
        check("p6_gnt0", 64'(bus.gnt_o), 64'b0001);
        tick();
        check_write("p6_wr0", 4'd5, 32'h11);
        bus.req_i = 4'b0100;
        #1;
        check("p6_gnt2", 64'(bus.gnt_o), 64'b0100);
        tick();
        check_write("p6_wr2", 4'd5, 32'h22);
        bus.req_i = 4'b0000;
        tick();
        tick();
        check("p6_mem5", 64'(mem[5]), 64'h22);
        check("p6_mem4", 64'(mem[4]), 64'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
